// File: rtl/tl_pkg.sv
// Shared light encodings and controller state encoding for the timed traffic-light controller.
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [2:0] {
        S_AG    = 3'd0,
        S_AY    = 3'd1,
        S_AR    = 3'd2,
        S_BG    = 3'd3,
        S_BY    = 3'd4,
        S_BR    = 3'd5,
        S_FLASH = 3'd6
    } state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: saturating up-counter, cleared synchronously whenever the controller changes phase.
module tl_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tl_cntr_timed.sv
// Two-street traffic-light controller with min/max green, timed yellow, all-red clearance
// and a night flashing-yellow mode.
//
//   state   | meaning
//   S_AG    | A green, B red
//   S_AY    | A yellow, B red
//   S_AR    | all red, clearing before B green (or flash)
//   S_BG    | B green, A red
//   S_BY    | B yellow, A red
//   S_BR    | all red, clearing before A green (or flash)
//   S_FLASH | both flashing yellow, blink toggles every FLASH_T cycles
module tl_cntr_timed
    import tl_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int FLASH_T   = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       flash_en,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       busy_clr
);

    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_M1  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(FLASH_T - 1);

    state_t           state, state_nxt;
    logic             blink, blink_nxt;
    logic             clr;
    logic [CNT_W-1:0] timer;
    logic             tmin, tmax;

    tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .cnt     (timer)
    );

    assign tmin = (timer >= GMIN_M1);
    assign tmax = (timer >= GMAX_M1);

    always_comb begin
        state_nxt = state;
        blink_nxt = blink;
        case (state)
            S_AG: if (tmin && (!Ta || flash_en || (Tb && tmax))) state_nxt = S_AY;
            S_AY: if (timer >= YEL_M1) state_nxt = S_AR;
            S_AR: begin
                if (timer >= ARED_M1) begin
                    if (flash_en) begin
                        state_nxt = S_FLASH;
                        blink_nxt = 1'b1;
                    end else begin
                        state_nxt = S_BG;
                    end
                end
            end
            S_BG: if (tmin && (!Tb || flash_en || (Ta && tmax))) state_nxt = S_BY;
            S_BY: if (timer >= YEL_M1) state_nxt = S_BR;
            S_BR: begin
                if (timer >= ARED_M1) begin
                    if (flash_en) begin
                        state_nxt = S_FLASH;
                        blink_nxt = 1'b1;
                    end else begin
                        state_nxt = S_AG;
                    end
                end
            end
            S_FLASH: begin
                // Leaving flash always goes through all-red so the first green starts clean.
                if (!flash_en) state_nxt = S_BR;
                else if (timer == FLASH_M1) blink_nxt = ~blink;
            end
            default: state_nxt = S_AG;
        endcase
    end

    // The timer restarts on every phase change and on every blink half-period.
    assign clr = (state_nxt != state) || (blink_nxt != blink);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_AG;
            blink <= 1'b1;
        end else begin
            state <= state_nxt;
            blink <= blink_nxt;
        end
    end

    always_comb begin
        La       = RED;
        Lb       = RED;
        busy_clr = 1'b0;
        case (state)
            S_AG: La = GREEN;
            S_AY: begin
                La       = YELLOW;
                busy_clr = 1'b1;
            end
            S_AR: busy_clr = 1'b1;
            S_BG: Lb = GREEN;
            S_BY: begin
                Lb       = YELLOW;
                busy_clr = 1'b1;
            end
            S_BR: busy_clr = 1'b1;
            S_FLASH: begin
                La = blink ? YELLOW : OFF;
                Lb = blink ? YELLOW : OFF;
            end
            default: ;
        endcase
    end

endmodule
